bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
- Sequential packed-BCD to unsigned binary converter; the inverse of the team's binary-to-BCD display path.
- Used to take decimal operands (switch/keypad entry, test stimulus) back into datapath binary.
- Processes one BCD digit per clock, most significant digit first, using acc = acc*10 + digit.
- Valid/ready handshake on input and output sides.

Parameters:
- DIGITS, 4, number of packed BCD digits in the input; legal range 1..8.
- BIN_W, 14, binary result width; must be >= ceil(log2(10^DIGITS)) (14 for 4 digits).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bcd_in holds a word to convert.
- in_ready  output  1  converter can accept a word.
- bcd_in  input  4*DIGITS  packed BCD; digit i is bits [4i+3:4i]; digit DIGITS-1 is most significant.
- out_valid  output  1  bin_out/err are valid.
- out_ready  input  1  consumer takes the result.
- bin_out  output  BIN_W  converted binary value.
- err  output  1  at least one input digit was > 9.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, accumulator=0, digit counter=0.
- Reset mid-conversion or mid-DONE aborts immediately. The partial result is discarded and never presented.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at an edge: capture bcd_in into the shift register, clear the accumulator, digit count and error flag, and go to CONV.
- CONV:
  - in_ready=0; in_valid is ignored.
  - Each edge consumes the top digit d: acc <= acc*10 + d, truncated to BIN_W bits.
  - If d > 9, the sticky error flag is set; d is still used arithmetically.
  - The shift register shifts left 4 bits and the count increments.
  - After the DIGITS-th digit edge, go to DONE.
- DONE:
  - out_valid=1. bin_out = acc, or 0 if the error flag is set. err = error flag.
  - Outputs are held stable while out_ready=0.
  - On out_valid && out_ready at an edge, go to IDLE.
  - The next input is accepted no earlier than the following edge; no same-cycle turnaround.
- Latency: out_valid is first high DIGITS cycles after the accept cycle.
  - With DIGITS=4, accept at edge k gives out_valid high in the cycle after edge k+4.
  - Minimum period between accepts is DIGITS+2 cycles.
- bin_out and err are registered outputs. They hold their last DONE value in IDLE and CONV; consumers must qualify with out_valid.
- Arithmetic:
  - Multiply by 10 is implemented as (acc<<3)+(acc<<1).
  - All internal sums are BIN_W+4 bits wide, then truncated.
  - With legal BIN_W and legal digits, no overflow is possible.
- Leading zero digits are legal and yield the small value (0x0007 -> 7).
- DIGITS=1 degenerates to a single CONV cycle.

Test Plan:
- Reset, then in_valid=1 with bcd_in=16'h1234, out_ready=1 -> in_ready drops the cycle after accept; 4 cycles later out_valid=1, bin_out=14'd1234 (0x04D2), err=0; returns to IDLE the next cycle.
- Boundary values: 16'h0000 -> 0; 16'h9999 -> 9999 (0x270F); 16'h0007 -> 7; all with err=0.
- Illegal digit: 16'h12A4 -> out_valid with err=1 and bin_out=0. The following legal conversion 16'h0042 -> 42 with err=0, showing the error flag does not stick across words.
- Backpressure: convert 16'h0500 with out_ready=0 for 6 cycles -> out_valid, bin_out=500 and err held stable; in_ready stays 0; in_valid pulses with new data are ignored. Raise out_ready -> one handshake, then IDLE.
- Input ignored while busy: assert in_valid with 16'h8888 during CONV of 16'h0001 -> result is 1. 16'h8888 is accepted only once the block returns to IDLE, and converts to 8888.
- Asynchronous reset: drop reset_n mid-CONV (not on a clock edge) -> outputs return to reset values immediately with no out_valid pulse. After release, 16'h0321 converts to 321 with normal latency.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: packed BCD to binary, one digit per clock MSD first, valid/ready on both sides
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t              state_q;
  logic [4*DIGITS-1:0] sr_q;
  logic [BIN_W-1:0]    acc_q, acc_d;
  logic [CW-1:0]       cnt_q;
  logic                bad_q, bad_d;
  logic                in_ready_q, out_valid_q, err_q;
  logic [BIN_W-1:0]    bin_q;
  logic [3:0]          dig;
  // next accumulator: acc*10 + top digit, summed at BIN_W+4 bits then truncated
  always_comb begin
    dig   = sr_q[4*DIGITS-1 -: 4];
    acc_d = BIN_W'(({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + (BIN_W+4)'(dig));
    bad_d = bad_q | (dig > 4'd9);
  end
  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          sr_q       <= bcd_in;
          acc_q      <= '0;
          cnt_q      <= '0;
          bad_q      <= 1'b0;
          in_ready_q <= 1'b0;
          state_q    <= CONV;
        end
        CONV: begin
          acc_q <= acc_d;
          bad_q <= bad_d;
          sr_q  <= sr_q << 4;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DIGITS-1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            bin_q       <= bad_d ? '0 : acc_d;
            err_q       <= bad_d;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign err       = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: vector table, corner sequences and random words against a decimal reference model
module tb_bcd_to_bin_seq;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  logic clk, reset_n, in_valid, in_ready, out_valid, out_ready, err;
  logic [4*DIGITS-1:0] bcd_in;
  logic [BIN_W-1:0] bin_out;
  int checks = 0, errors = 0;
  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        e;
  } vec_t;
  vec_t tbl[6];

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready),
    .bin_out(bin_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // decimal reference: weight each digit by its power of ten
  task automatic ref_conv(input logic [15:0] w, output logic [13:0] b, output logic e);
    int v = 0;
    e = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      int d = int'((w >> (4*i)) & 16'hF);
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    b = e ? 14'd0 : 14'(v);
  endtask

  // called at a negedge; hold>0 stalls the consumer, busy keeps in_valid high with nxt during conversion
  task automatic convert(input logic [15:0] w, input logic [13:0] eb, input logic ee,
                         input int hold, input logic busy, input logic [15:0] nxt, input string nm);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    bcd_in    = w;
    out_ready = (hold == 0);
    @(negedge clk);
    if (busy) bcd_in = nxt;
    else in_valid = 1'b0;
    chk({nm, " in_ready busy"}, 32'(in_ready), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({nm, " latency"}, 32'(n), 32'(DIGITS));
    chk({nm, " bin_out"}, 32'(bin_out), 32'(eb));
    chk({nm, " err"}, 32'(err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      bcd_in   = 16'($urandom);
      @(negedge clk);
      chk({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " hold bin_out"}, 32'(bin_out), 32'(eb));
      chk({nm, " hold err"}, 32'(err), 32'(ee));
      chk({nm, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    if (hold > 0) in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
    chk({nm, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] w;
    logic [13:0] eb;
    logic ee;
    tbl[0] = '{16'h1234, 14'd1234, 1'b0};
    tbl[1] = '{16'h0000, 14'd0,    1'b0};
    tbl[2] = '{16'h9999, 14'd9999, 1'b0};
    tbl[3] = '{16'h0007, 14'd7,    1'b0};
    tbl[4] = '{16'h12A4, 14'd0,    1'b1};
    tbl[5] = '{16'h0042, 14'd42,   1'b0};
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bcd_in = '0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset bin_out", 32'(bin_out), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      convert(tbl[i].bcd, tbl[i].bin, tbl[i].e, 0, 1'b0, 16'h0, $sformatf("vec%0d", i));
    convert(16'h0500, 14'd500, 1'b0, 6, 1'b0, 16'h0, "backpressure");
    convert(16'h0001, 14'd1, 1'b0, 0, 1'b1, 16'h8888, "busy");
    convert(16'h8888, 14'd8888, 1'b0, 0, 1'b0, 16'h0, "after_busy");
    for (int i = 0; i < 30; i++) begin
      w = '0;
      for (int k = 0; k < DIGITS; k++)
        w[4*k +: 4] = 4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
      ref_conv(w, eb, ee);
      convert(w, eb, ee, int'($urandom_range(0, 2)), 1'b0, 16'h0, $sformatf("rand%0d", i));
    end
    in_valid = 1'b1;
    bcd_in   = 16'h9876;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async in_ready", 32'(in_ready), 32'd1);
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async bin_out", 32'(bin_out), 32'd0);
    chk("async err", 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("async no out_valid", 32'(out_valid), 32'd0);
    end
    reset_n = 1'b1;
    convert(16'h0321, 14'd321, 1'b0, 0, 1'b0, 16'h0, "post_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
